sc_game_flow_ctrl: RTL and testbench

Parametrised game-flow controller that replaces the four-state main state machine of the Frogger top level. It adds lives, multi-level progression, a timed respawn/level-transition wait and an optional pause mode. It sits between the debounced push-buttons and the lane/frog datapath: it issues the one-cycle load pulse that reinitialises the playfield and gates the datapath with a play-enable.

---
 rtl/sc_game_flow_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sc_game_flow_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_game_flow_ctrl.sv
// Game-flow controller for the Frogger top level: lives, levels, timed respawn/level-up wait.
// Optional pause mode is compiled in with `define SC_GAME_FLOW_PAUSE_EN.
module sc_game_flow_ctrl #(
  parameter int LIVES_INIT  = 3,
  parameter int LIFE_WIDTH  = 2,
  parameter int LEVELS      = 4,
  parameter int LEVEL_WIDTH = 2,
  parameter int WAIT_CYCLES = 50000000,
  parameter int WAIT_WIDTH  = 26
) (
  input  logic                   SC_MAIN_STATEMACHINE_CLOCK_50,
  input  logic                   SC_MAIN_STATEMACHINE_RESET_InHigh,
  input  logic                   start_InLow,
  input  logic                   death_InLow,
  input  logic                   goal_InLow,
`ifdef SC_GAME_FLOW_PAUSE_EN
  input  logic                   pause_InLow,
`endif
  output logic [2:0]             state_out,
  output logic                   load_out,
  output logic                   play_en_out,
  output logic [LIFE_WIDTH-1:0]  lives_out,
  output logic [LEVEL_WIDTH-1:0] level_out,
  output logic                   gameover_out,
  output logic                   win_out
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_PLAY     = 3'd2,
    ST_RESPAWN  = 3'd3,
    ST_LEVELUP  = 3'd4,
    ST_GAMEOVER = 3'd5,
    ST_WIN      = 3'd6,
    ST_PAUSE    = 3'd7
  } state_t;

  localparam logic [LIFE_WIDTH-1:0]  LIVES_LOAD = LIFE_WIDTH'(LIVES_INIT);
  localparam logic [LIFE_WIDTH-1:0]  LIFE_ONE   = LIFE_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_LAST = LEVEL_WIDTH'(LEVELS - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE  = LEVEL_WIDTH'(1);
  localparam logic [WAIT_WIDTH-1:0]  WAIT_LAST  = WAIT_WIDTH'(WAIT_CYCLES - 1);
  localparam logic [WAIT_WIDTH-1:0]  WAIT_ONE   = WAIT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [LIFE_WIDTH-1:0]  lives_q, lives_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [WAIT_WIDTH-1:0]  wait_q, wait_d;
  logic                   start_prev_q;
  logic                   start_edge;
  logic                   state_legal;

  // Buttons idle high, so the previous-value registers reset to 1 to avoid a phantom edge.
  assign start_edge = start_prev_q & ~start_InLow;

`ifdef SC_GAME_FLOW_PAUSE_EN
  logic pause_prev_q;
  logic pause_edge;

  assign pause_edge = pause_prev_q & ~pause_InLow;

  always_ff @(posedge SC_MAIN_STATEMACHINE_CLOCK_50 or posedge SC_MAIN_STATEMACHINE_RESET_InHigh) begin
    if (SC_MAIN_STATEMACHINE_RESET_InHigh) begin
      pause_prev_q <= 1'b1;
    end else begin
      pause_prev_q <= pause_InLow;
    end
  end
`endif

  // State register together with the counters it owns.
  always_ff @(posedge SC_MAIN_STATEMACHINE_CLOCK_50 or posedge SC_MAIN_STATEMACHINE_RESET_InHigh) begin
    if (SC_MAIN_STATEMACHINE_RESET_InHigh) begin
      state_q      <= ST_IDLE;
      lives_q      <= '0;
      level_q      <= '0;
      wait_q       <= '0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      wait_q       <= wait_d;
      start_prev_q <= start_InLow;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_ARM;
          lives_d = LIVES_LOAD;
          level_d = '0;
        end
      end
      ST_ARM: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // death outranks goal, and both outrank a pause edge.
        if (!death_InLow) begin
          if (lives_q == LIFE_ONE) begin
            lives_d = '0;
            state_d = ST_GAMEOVER;
          end else begin
            lives_d = lives_q - LIFE_ONE;
            wait_d  = '0;
            state_d = ST_RESPAWN;
          end
        end else if (!goal_InLow) begin
          if (level_q == LEVEL_LAST) begin
            state_d = ST_WIN;
          end else begin
            level_d = level_q + LEVEL_ONE;
            wait_d  = '0;
            state_d = ST_LEVELUP;
          end
        end
`ifdef SC_GAME_FLOW_PAUSE_EN
        else if (pause_edge) begin
          state_d = ST_PAUSE;
        end
`endif
      end
      ST_RESPAWN, ST_LEVELUP: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_ARM;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      ST_GAMEOVER, ST_WIN: begin
        if (start_edge) begin
          state_d = ST_IDLE;
        end
      end
`ifdef SC_GAME_FLOW_PAUSE_EN
      ST_PAUSE: begin
        if (pause_edge) begin
          state_d = ST_PLAY;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs; an unreachable code drives everything but state_out to 0.
  always_comb begin
    load_out     = 1'b0;
    play_en_out  = 1'b0;
    gameover_out = 1'b0;
    win_out      = 1'b0;
    state_legal  = 1'b1;
    case (state_q)
      ST_IDLE:     ;
      ST_ARM:      load_out     = 1'b1;
      ST_PLAY:     play_en_out  = 1'b1;
      ST_RESPAWN:  ;
      ST_LEVELUP:  ;
      ST_GAMEOVER: gameover_out = 1'b1;
      ST_WIN:      win_out      = 1'b1;
`ifdef SC_GAME_FLOW_PAUSE_EN
      ST_PAUSE:    ;
`endif
      default:     state_legal  = 1'b0;
    endcase
    lives_out = state_legal ? lives_q : '0;
    level_out = state_legal ? level_q : '0;
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_sc_game_flow_ctrl.sv
// Self-checking bench for sc_game_flow_ctrl: directed scenarios followed by random play,
// every cycle compared against a game-rules model. Pause scenarios run with SC_GAME_FLOW_PAUSE_EN.
module tb_sc_game_flow_ctrl;

  localparam int LIVES_INIT  = 3;
  localparam int LIFE_WIDTH  = 2;
  localparam int LEVELS      = 2;
  localparam int LEVEL_WIDTH = 2;
  localparam int WAIT_CYCLES = 4;
  localparam int WAIT_WIDTH  = 3;
  localparam int EW          = 3 + 1 + 1 + LIFE_WIDTH + LEVEL_WIDTH + 2;

  localparam int S_IDLE = 0, S_ARM = 1, S_PLAY = 2, S_RESPAWN = 3,
                 S_LEVELUP = 4, S_GAMEOVER = 5, S_WIN = 6, S_PAUSE = 7;

  logic                   clk;
  logic                   rst;
  logic                   start_n, death_n, goal_n, pause_n;
  logic [2:0]             state_out;
  logic                   load_out, play_en_out, gameover_out, win_out;
  logic [LIFE_WIDTH-1:0]  lives_out;
  logic [LEVEL_WIDTH-1:0] level_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];

  // reference model: phase of the game plus counts
  int m_phase, m_lives, m_level, m_wait_left;
  bit m_start_prev, m_pause_prev;

  sc_game_flow_ctrl #(
    .LIVES_INIT (LIVES_INIT),
    .LIFE_WIDTH (LIFE_WIDTH),
    .LEVELS     (LEVELS),
    .LEVEL_WIDTH(LEVEL_WIDTH),
    .WAIT_CYCLES(WAIT_CYCLES),
    .WAIT_WIDTH (WAIT_WIDTH)
  ) dut (
    .SC_MAIN_STATEMACHINE_CLOCK_50    (clk),
    .SC_MAIN_STATEMACHINE_RESET_InHigh(rst),
    .start_InLow                      (start_n),
    .death_InLow                      (death_n),
    .goal_InLow                       (goal_n),
`ifdef SC_GAME_FLOW_PAUSE_EN
    .pause_InLow                      (pause_n),
`endif
    .state_out                        (state_out),
    .load_out                         (load_out),
    .play_en_out                      (play_en_out),
    .lives_out                        (lives_out),
    .level_out                        (level_out),
    .gameover_out                     (gameover_out),
    .win_out                          (win_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase      = S_IDLE;
    m_lives      = 0;
    m_level      = 0;
    m_wait_left  = 0;
    m_start_prev = 1'b1;
    m_pause_prev = 1'b1;
  endfunction

  function automatic void model_step(input bit s, input bit d, input bit g, input bit p);
    bit s_edge;
    bit p_edge;
    s_edge = m_start_prev && !s;
    p_edge = m_pause_prev && !p;
`ifndef SC_GAME_FLOW_PAUSE_EN
    p_edge = 1'b0;
`endif
    m_start_prev = s;
    m_pause_prev = p;
    if (m_phase == S_IDLE) begin
      if (s_edge) begin
        m_phase = S_ARM;
        m_lives = LIVES_INIT;
        m_level = 0;
      end
    end else if (m_phase == S_ARM) begin
      m_phase = S_PLAY;
    end else if (m_phase == S_PLAY) begin
      if (!d) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_phase = S_GAMEOVER;
        else begin
          m_phase = S_RESPAWN;
          m_wait_left = WAIT_CYCLES;
        end
      end else if (!g) begin
        if (m_level == LEVELS - 1) m_phase = S_WIN;
        else begin
          m_level = m_level + 1;
          m_phase = S_LEVELUP;
          m_wait_left = WAIT_CYCLES;
        end
      end else if (p_edge) begin
        m_phase = S_PAUSE;
      end
    end else if (m_phase == S_RESPAWN || m_phase == S_LEVELUP) begin
      m_wait_left = m_wait_left - 1;
      if (m_wait_left == 0) m_phase = S_ARM;
    end else if (m_phase == S_GAMEOVER || m_phase == S_WIN) begin
      if (s_edge) m_phase = S_IDLE;
    end else if (m_phase == S_PAUSE) begin
      if (p_edge) m_phase = S_PLAY;
    end
  endfunction

  function automatic logic [EW-1:0] model_outputs();
    logic [EW-1:0] v;
    v = {3'(m_phase), 1'(m_phase == S_ARM), 1'(m_phase == S_PLAY),
         LIFE_WIDTH'(m_lives), LEVEL_WIDTH'(m_level),
         1'(m_phase == S_GAMEOVER), 1'(m_phase == S_WIN)};
    return v;
  endfunction

  // scoreboard: compare DUT against oldest expected entry
  task automatic scoreboard_check();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("state",    32'(state_out),    32'(e[EW-1 -: 3]));
      check_eq("load",     32'(load_out),     32'(e[EW-4]));
      check_eq("play_en",  32'(play_en_out),  32'(e[EW-5]));
      check_eq("lives",    32'(lives_out),    32'(e[LIFE_WIDTH+LEVEL_WIDTH+1 -: LIFE_WIDTH]));
      check_eq("level",    32'(level_out),    32'(e[LEVEL_WIDTH+1 -: LEVEL_WIDTH]));
      check_eq("gameover", 32'(gameover_out), 32'(e[1]));
      check_eq("win",      32'(win_out),      32'(e[0]));
    end
  endtask

  // driver: apply inputs mid-cycle, advance one edge, check the result
  task automatic drive_cycle(input bit s, input bit d, input bit g, input bit p);
    @(negedge clk);
    start_n = s;
    death_n = d;
    goal_n  = g;
    pause_n = p;
    @(posedge clk);
    model_step(s, d, g, p);
    exp_q.push_back(model_outputs());
    #1;
    scoreboard_check();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, 32'(state_out), 32'd0);
    check_eq({tag, "_outs"},
             32'({load_out, play_en_out, gameover_out, win_out, lives_out, level_out}), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    start_n = 1'b1; death_n = 1'b1; goal_n = 1'b1; pause_n = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check_all_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int arm_count;
    rst = 1'b0;
    start_n = 1'b1; death_n = 1'b1; goal_n = 1'b1; pause_n = 1'b1;
    model_reset();
    #2;
    apply_reset();

    // start edge: IDLE -> ARM (one load cycle) -> PLAY
    idle_cycles(2);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("start_arm", 32'(state_out), S_ARM);
    check_eq("start_load", 32'(load_out), 32'd1);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("start_play", 32'(state_out), S_PLAY);
    check_eq("start_load_gone", 32'(load_out), 32'd0);
    check_eq("start_lives", 32'(lives_out), LIVES_INIT);
    check_eq("start_level", 32'(level_out), 32'd0);

    // death and goal together: death wins
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("dg_state", 32'(state_out), S_RESPAWN);
    check_eq("dg_lives", 32'(lives_out), LIVES_INIT - 1);
    check_eq("dg_level", 32'(level_out), 32'd0);
    idle_cycles(WAIT_CYCLES - 1);
    check_eq("respawn_last", 32'(state_out), S_RESPAWN);
    idle_cycles(1);
    check_eq("respawn_arm", 32'(state_out), S_ARM);
    idle_cycles(1);

    // goal: LEVELUP then ARM on level 1, then WIN on the last level
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("goal_levelup", 32'(state_out), S_LEVELUP);
    check_eq("goal_level", 32'(level_out), 32'd1);
    idle_cycles(WAIT_CYCLES + 1);
    check_eq("levelup_play", 32'(state_out), S_PLAY);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("win_flag", 32'(win_out), 32'd1);
    idle_cycles(3);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("win_to_idle", 32'(state_out), S_IDLE);
    check_eq("win_keep_level", 32'(level_out), 32'd1);

    // start held low for 100 cycles: exactly one ARM
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    arm_count = 0;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
      if (state_out == 3'(S_ARM)) arm_count++;
    end
    check_eq("start_hold_arms", 32'(arm_count), 32'd1);

    // death held low: 3 -> 2 -> 1 -> 0 and GAMEOVER
    for (int i = 0; i < 3 * (WAIT_CYCLES + 2) + 4; i++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("gameover_flag", 32'(gameover_out), 32'd1);
    check_eq("gameover_lives", 32'(lives_out), 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("gameover_to_idle", 32'(state_out), S_IDLE);

    // reset mid-RESPAWN with the wait counter at 2
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("pre_reset_respawn", 32'(state_out), S_RESPAWN);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

`ifdef SC_GAME_FLOW_PAUSE_EN
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    idle_cycles(1);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("pause_enter", 32'(state_out), S_PAUSE);
    check_eq("pause_play_en", 32'(play_en_out), 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("pause_ignores_start", 32'(state_out), S_PAUSE);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("pause_resume", 32'(state_out), S_PLAY);
    check_eq("pause_no_load", 32'(load_out), 32'd0);
    check_eq("pause_lives", 32'(lives_out), LIVES_INIT);
    idle_cycles(1);
`endif

    // random play against the model
    for (int i = 0; i < 4000; i++) begin
      drive_cycle(($urandom_range(0, 5) != 0), ($urandom_range(0, 11) != 0),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, expected $finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
